// File: rtl/rem_sched.sv
// rem_sched: multi-slot reminder scheduler.
// One countdown timer time-shared round-robin.
module rem_sched #(
  parameter  int SLOTS = 4,
  parameter  int DW    = 32,
  localparam int IW    = $clog2(SLOTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set,
  input  logic [IW-1:0]    set_id,
  input  logic [DW-1:0]    dur,
  input  logic             cancel,
  input  logic [IW-1:0]    cancel_id,
  output logic [SLOTS-1:0] notif,
  output logic [SLOTS-1:0] pending,
  output logic             active,
  output logic [IW-1:0]    active_id,
  output logic [DW-1:0]    remain,
  output logic             set_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ALERT = 2'd2
  } st_t;

  st_t              state;
  st_t              state_n;
  logic [SLOTS-1:0] pend;
  logic [SLOTS-1:0] pend_n;
  logic [SLOTS-1:0] notif_q;
  logic [SLOTS-1:0] notif_n;
  logic [DW-1:0]    dur_q [SLOTS];
  logic [DW-1:0]    cnt;
  logic [DW-1:0]    cnt_n;
  logic [IW-1:0]    last;
  logic [IW-1:0]    last_n;
  logic [IW-1:0]    aid;
  logic [IW-1:0]    aid_n;
  logic             err_q;

  logic [SLOTS-1:0] set_oh;
  logic [SLOTS-1:0] can_oh;
  logic [SLOTS-1:0] req;
  logic             busy;
  logic             same;
  logic             acc;
  logic             run_can;
  logic             found;
  logic [IW-1:0]    sel;
  logic [IW-1:0]    idx;

  // Request decode: one-hot masks and set acceptance.
  always_comb begin
    set_oh         = '0;
    can_oh         = '0;
    set_oh[set_id] = set;
    can_oh[cancel_id] = cancel;
    busy    = (state == RUN || state == ALERT)
              && (set_id == aid);
    same    = cancel && (cancel_id == set_id);
    acc     = set && (dur != '0) && !pend[set_id]
              && !busy && !same;
    run_can = (state == RUN) && cancel
              && (cancel_id == aid);
    req     = pend & ~can_oh;
  end

  // Round-robin pick: first request after last, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = last;
    idx   = last;
    for (int k = 1; k <= SLOTS; k++) begin
      idx = last + k[IW-1:0];
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // Next-state, counter, grant and expiry pulse.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    aid_n   = aid;
    last_n  = last;
    notif_n = '0;
    pend_n  = (pend & ~can_oh)
              | (acc ? set_oh : '0);
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n     = RUN;
          aid_n       = sel;
          last_n      = sel;
          cnt_n       = dur_q[sel] - DW'(1);
          pend_n[sel] = 1'b0;
        end
      end
      RUN: begin
        if (run_can) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == '0) begin
          state_n      = ALERT;
          notif_n[aid] = 1'b1;
        end else begin
          cnt_n = cnt - DW'(1);
        end
      end
      ALERT: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // FSM and control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pend    <= '0;
      cnt     <= '0;
      last    <= IW'(SLOTS - 1);
      aid     <= '0;
      notif_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      pend    <= pend_n;
      cnt     <= cnt_n;
      last    <= last_n;
      aid     <= aid_n;
      notif_q <= notif_n;
      err_q   <= set && !acc;
    end
  end

  // Per-slot duration storage, written on accepted set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) begin
        dur_q[i] <= '0;
      end
    end else if (acc) begin
      dur_q[set_id] <= dur;
    end
  end

  assign notif     = notif_q;
  assign pending   = pend;
  assign active    = (state == RUN);
  assign active_id = aid;
  assign remain    = (state == RUN) ? cnt : '0;
  assign set_err   = err_q;

endmodule

// File: doc/rem_sched.md
# rem_sched

Multi-slot reminder scheduler. It holds up to SLOTS pending reminders and time-shares one countdown timer between them, granting slots in round-robin order. It issues a one-cycle per-slot notification when a slot's duration expires. It sits between software/user request logic and the notification outputs, replacing one timer per reminder.

## Interface
- SLOTS, 4: number of reminder slots; power of two, ≥2. IW = log2(SLOTS).
- DW, 32: duration and counter width.

- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- set  in  1  request to arm slot set_id with duration dur.
- set_id  in  IW  slot to arm.
- dur  in  DW  duration in cycles, unsigned; 0 is illegal.
- cancel  in  1  request to cancel slot cancel_id.
- cancel_id  in  IW  slot to cancel.
- notif  out  SLOTS  one-hot, one-cycle expiry pulse for a slot, registered.
- pending  out  SLOTS  slot is armed and waiting for the timer.
- active  out  1  the timer is running (state RUN).
- active_id  out  IW  slot that owns the timer; valid while active.
- remain  out  DW  current counter value in RUN; 0 otherwise.
- set_err  out  1  one-cycle registered pulse when a set is rejected.

## Operation
- Per-slot storage: pend[i] and dur_q[i]. The FSM holds state, cnt[DW] and last[IW], the round-robin pointer.
- Set acceptance, sampled every edge in any state:
  - Accept when dur != 0, pend[set_id] = 0, and set_id is not the slot in RUN or ALERT. On accept: pend <= 1, dur_q <= dur.
  - Otherwise reject: set_err <= 1 next cycle, no state change.
- Cancel:
  - Slot pending: pend[cancel_id] <= 0.
  - Slot in RUN: abort. Go to IDLE with no notif; cnt cleared.
  - Slot in ALERT or idle: no effect.
- Cancel and set to the same slot in the same cycle: cancel wins, the set is rejected (set_err).
- FSM states: IDLE, RUN, ALERT.
  - IDLE: if any pend bit is set, select the first set bit searching from (last+1) mod SLOTS upward with wrap. Then active_id <= sel, last <= sel, pend[sel] <= 0, cnt <= dur_q[sel] - 1, go to RUN. Otherwise stay in IDLE.
  - RUN: if cancel targets active_id, go to IDLE. Else if cnt == 0, go to ALERT and set notif[active_id] <= 1. Else cnt <= cnt - 1.
  - ALERT: notif is high for this cycle only. Go to IDLE; notif <= 0.
  - Unreachable state encoding: go to IDLE, notif <= 0.
- A set accepted on the same edge as an IDLE grant is not visible to that grant's arbitration; it competes at the next IDLE edge.
- Width rules:
  - cnt is loaded with dur_q - 1. dur_q is never 0, so no underflow.
  - Maximum duration is 2^DW - 1 cycles.
  - The wrap in the round-robin search is modulo SLOTS.

## Timing
- Reset values:
  - notif = 0, pending = 0, active = 0, active_id = 0, remain = 0, set_err = 0.
  - state = IDLE, cnt = 0, last = SLOTS-1, so slot 0 has first priority. All dur_q = 0.
- Reset mid-operation: all pending and active reminders are lost, and no notif is issued.
- Latency, timer free: set sampled at edge E0. Grant at E1. notif is high during the cycle following edge E(dur+1), i.e. dur+1 cycles after set.
- Back-to-back: after ALERT, the next grant occurs on the edge that leaves IDLE. The next notif therefore comes at the earliest dur_next + 2 cycles after the previous notif.
- pending, active, active_id and remain are registered state, valid the cycle after the causing edge.

## Test plan
- Single reminder: set slot 2 with dur=5 at E0 -> active from E1, remain counts 4,3,2,1,0; notif = 4'b0100 for exactly one cycle after E6; pending returns to 0.
- Minimum duration: set slot 0 with dur=1 -> notif[0] one cycle after E2. Set with dur=0 -> set_err pulse, pending unchanged.
- Round robin: arm slots 1, 3, 0 (dur=3 each) while slot 2 runs -> service order 3, 0, 1. Each notif is spaced 5 cycles from the previous one.
- Cancel: cancel the active slot mid-RUN (remain=2) -> no notif, the FSM returns to IDLE, and the next pending slot is granted. Cancel a pending slot -> its pend bit clears and it is never granted.
- Conflicts:
  - Re-set a pending slot -> set_err, dur_q unchanged.
  - Set and cancel the same free slot in the same cycle -> set_err, slot stays free.
  - Set the slot in ALERT -> set_err.
- Reset: assert rst asynchronously mid-RUN with 3 slots pending -> all outputs go to 0 immediately, and no notif appears after release.
